// File: rtl/principal_scan_gen.sv
// ---------------------------------------------------------------------------
// PrincipalScanGen (module principal_scan_gen)
//
// Walks a principal lattice coordinate (h,v) in raster order over an
// HPIXELS x VPIXELS grid and presents one beat per accepted handshake.
// Each beat carries, for every one of Q direction channels, a column, a row
// and a flat BRAM address. Channels whose REV_MASK bit is set see the lattice
// mirrored in both axes, so they sweep the grid from the opposite corner.
//
// Parameters:
//   HPIXELS  - lattice width in cells (>= 2)
//   VPIXELS  - lattice height in cells (>= 2)
//   Q        - number of direction channels (1..9)
//   REV_MASK - Q bits, bit i set = channel i uses reversed scan order
//
// Ports:
//   clk_in          - single clock
//   rst_in          - asynchronous active-high reset
//   start_in        - frame start request, honoured only while idle
//   ready_in        - downstream accepts the current beat
//   valid_out       - beat on the outputs is valid
//   hor_out         - per-channel column
//   vert_out        - per-channel row
//   addr_out        - per-channel address (row * HPIXELS + column)
//   first_out       - beat is the first of the frame
//   last_out        - beat is the last of the frame
//   busy_out        - a frame is in progress (SCAN or DONE)
//   done_out        - one-cycle end-of-frame pulse
//   frame_count_out - 16-bit completed-frame counter (only with
//                     PRINCIPAL_SCAN_FRAME_COUNT_EN defined)
//
// Optional feature macro: PRINCIPAL_SCAN_FRAME_COUNT_EN
// ---------------------------------------------------------------------------
module principal_scan_gen #(
   parameter int HPIXELS = 64,
   parameter int VPIXELS = 64,
   parameter int Q = 9,
   parameter logic [Q-1:0] REV_MASK = 9'h078
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic start_in,
   input  logic ready_in,
   output logic valid_out,
   output logic [Q-1:0][$clog2(HPIXELS)-1:0] hor_out,
   output logic [Q-1:0][$clog2(VPIXELS)-1:0] vert_out,
   output logic [Q-1:0][$clog2(HPIXELS*VPIXELS)-1:0] addr_out,
   output logic first_out,
   output logic last_out,
   output logic busy_out,
   output logic done_out
`ifdef PRINCIPAL_SCAN_FRAME_COUNT_EN
   ,
   output logic [15:0] frame_count_out
`endif
);

   localparam int HW = $clog2(HPIXELS);
   localparam int VW = $clog2(VPIXELS);
   localparam int AW = $clog2(HPIXELS*VPIXELS);
   localparam logic [HW-1:0] HMAX = HW'(HPIXELS-1);
   localparam logic [VW-1:0] VMAX = VW'(VPIXELS-1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} stateT;

   stateT state;
   logic [HW-1:0] hCount;
   logic [VW-1:0] vCount;
   logic [HW-1:0] nextH;
   logic [VW-1:0] nextV;
   logic [Q-1:0][HW-1:0] nextHor;
   logic [Q-1:0][VW-1:0] nextVert;
   logic [Q-1:0][AW-1:0] nextAddr;
   logic accept;

   // A beat is consumed only on a full handshake; valid_out is high only in
   // SCAN, so this also implies we are scanning.
   assign accept = valid_out & ready_in;

   // The coordinate that the next registered beat should carry. Outside SCAN
   // this is (0,0), which is exactly what a fresh frame has to present first,
   // so the IDLE->SCAN load can reuse the same channel mapping below.
   always_comb begin
      nextH = '0;
      nextV = '0;
      if (state == SCAN) begin
         if (hCount == HMAX) begin
            nextH = '0;
            nextV = vCount + 1'b1;
         end else begin
            nextH = hCount + 1'b1;
            nextV = vCount;
         end
      end
   end

   // Per-channel view of the upcoming coordinate. Reversed channels mirror
   // both axes; the address is formed at 32-bit width and then cut down to
   // the address width so it is registered alongside the column and row.
   always_comb begin
      nextHor  = '0;
      nextVert = '0;
      nextAddr = '0;
      for (int i = 0; i < Q; i++) begin
         if (REV_MASK[i]) begin
            nextHor[i]  = HMAX - nextH;
            nextVert[i] = VMAX - nextV;
         end else begin
            nextHor[i]  = nextH;
            nextVert[i] = nextV;
         end
         nextAddr[i] = AW'(int'(nextVert[i]) * HPIXELS + int'(nextHor[i]));
      end
   end

   // Main sequencer. Every output is registered here so nothing changes
   // while the downstream stalls: in SCAN the registers only load on an
   // accepted beat. The last beat is recognised from the registered
   // last_out flag, which was precomputed when that beat was loaded.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state     <= IDLE;
         hCount    <= '0;
         vCount    <= '0;
         valid_out <= 1'b0;
         first_out <= 1'b0;
         last_out  <= 1'b0;
         busy_out  <= 1'b0;
         done_out  <= 1'b0;
         hor_out   <= '0;
         vert_out  <= '0;
         addr_out  <= '0;
      end else begin
         done_out <= 1'b0;
         case (state)
            IDLE: begin
               if (start_in) begin
                  state     <= SCAN;
                  hCount    <= '0;
                  vCount    <= '0;
                  valid_out <= 1'b1;
                  first_out <= 1'b1;
                  last_out  <= 1'b0;
                  busy_out  <= 1'b1;
                  hor_out   <= nextHor;
                  vert_out  <= nextVert;
                  addr_out  <= nextAddr;
               end
            end
            SCAN: begin
               if (accept) begin
                  if (last_out) begin
                     state     <= DONE;
                     valid_out <= 1'b0;
                     first_out <= 1'b0;
                     last_out  <= 1'b0;
                     done_out  <= 1'b1;
                  end else begin
                     hCount    <= nextH;
                     vCount    <= nextV;
                     first_out <= 1'b0;
                     last_out  <= (nextH == HMAX) && (nextV == VMAX);
                     hor_out   <= nextHor;
                     vert_out  <= nextVert;
                     addr_out  <= nextAddr;
                  end
               end
            end
            DONE: begin
               state    <= IDLE;
               busy_out <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef PRINCIPAL_SCAN_FRAME_COUNT_EN
   // Completed-frame counter; bumps once per DONE cycle and wraps naturally
   // at 16 bits.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         frame_count_out <= '0;
      end else if (state == DONE) begin
         frame_count_out <= frame_count_out + 16'd1;
      end
   end
`endif

endmodule
